// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetch requests, tracks responses in a
// circular buffer, and presents instructions to decode in program order.
module fetch_unit #(
  parameter int unsigned    XLEN     = 64,
  parameter int unsigned    ADDR_W   = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_sync,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [XLEN-1:0]   instr_pc_o,
  input  logic              instr_ready_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] r_pc;
  logic            r_run;
  logic [PW-1:0]   r_alloc;
  logic [PW-1:0]   r_fill;
  logic [PW-1:0]   r_head;
  logic [CW-1:0]   r_used;
  logic [CW-1:0]   r_pend;
  logic [CW-1:0]   r_disc;
  logic [XLEN-1:0] r_ent_pc    [DEPTH];
  logic [31:0]     r_ent_instr [DEPTH];
  logic [DEPTH-1:0] r_ent_filled;

  logic [CW:0] w_occ;
  logic        w_req;
  logic        w_gnt;
  logic        w_drop;
  logic        w_fill;
  logic        w_valid;
  logic        w_pop;
  logic        w_unused_pc_lsb;

  // Occupancy counts responses still owed for flushed fetches as well as live entries.
  assign w_occ   = (CW+1)'(r_used) + (CW+1)'(r_disc);
  assign w_req   = r_run & ~redirect_i & (w_occ < (CW+1)'(DEPTH));
  assign w_gnt   = w_req & imem_gnt_i;
  assign w_drop  = imem_rvalid_i & (r_disc != '0);
  assign w_fill  = imem_rvalid_i & (r_disc == '0) & (r_pend != '0);
  assign w_valid = (r_used != '0) & r_ent_filled[r_head];
  assign w_pop   = w_valid & instr_ready_i & ~redirect_i;

  assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_pc[ADDR_W-1:0];
  assign instr_valid_o = w_valid;
  assign instr_o       = r_ent_instr[r_head];
  assign instr_pc_o    = r_ent_pc[r_head];

  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) begin
      r_pc         <= RESET_PC;
      r_run        <= 1'b0;
      r_alloc      <= '0;
      r_fill       <= '0;
      r_head       <= '0;
      r_used       <= '0;
      r_pend       <= '0;
      r_disc       <= '0;
      r_ent_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent_pc[i]    <= '0;
        r_ent_instr[i] <= '0;
      end
    end else begin
      r_run <= 1'b1;
      if (redirect_i) begin
        // Unfilled entries become responses to drop; one arriving now is consumed here.
        r_pc         <= {redirect_pc_i[XLEN-1:2], 2'b00};
        r_alloc      <= '0;
        r_fill       <= '0;
        r_head       <= '0;
        r_used       <= '0;
        r_pend       <= '0;
        r_ent_filled <= '0;
        r_disc       <= r_disc + r_pend - CW'(w_drop | w_fill);
      end else begin
        if (w_gnt) begin
          r_ent_pc[r_alloc]     <= r_pc;
          r_ent_filled[r_alloc] <= 1'b0;
          r_alloc               <= r_alloc + PW'(1);
          r_pc                  <= r_pc + XLEN'(4);
        end
        if (w_fill) begin
          r_ent_instr[r_fill]  <= imem_rdata_i;
          r_ent_filled[r_fill] <= 1'b1;
          r_fill               <= r_fill + PW'(1);
        end
        if (w_drop) begin
          r_disc <= r_disc - CW'(1);
        end
        if (w_pop) begin
          r_ent_filled[r_head] <= 1'b0;
          r_head               <= r_head + PW'(1);
        end
        r_used <= r_used + CW'(w_gnt) - CW'(w_pop);
        r_pend <= r_pend + CW'(w_gnt) - CW'(w_fill);
      end
    end
  end

  // A response with nothing outstanding means the memory side broke the protocol.
  a_orphan_rsp: assert property (@(posedge clk) disable iff (reset_sync)
    !(imem_rvalid_i && (r_disc == '0) && (r_pend == '0)));

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 64, width of PC and redirect target.
REQ-002 Parameter ADDR_W, default 32, instruction-memory address width; imem_addr_o = fetch PC[ADDR_W-1:0].
REQ-003 Parameter DEPTH, default 4, fetch-buffer entries; power of two, >= 2.
REQ-004 Parameter RESET_PC, default 0, XLEN-bit fetch PC after reset.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset_sync  in  1  asynchronous, active-high reset.
REQ-007 redirect_i  in  1  flush buffer and restart fetch at redirect_pc_i.
REQ-008 redirect_pc_i  in  XLEN  new fetch PC; bits [1:0] ignored (treated as 0).
REQ-009 imem_req_o  out  1  fetch request valid.
REQ-010 imem_addr_o  out  ADDR_W  fetch address.
REQ-011 imem_gnt_i  in  1  request accepted when imem_req_o & imem_gnt_i.
REQ-012 imem_rvalid_i  in  1  response valid; responses return in grant order, >= 1 cycle after grant.
REQ-013 imem_rdata_i  in  32  response instruction word.
REQ-014 instr_valid_o  out  1  buffer head holds a filled instruction.
REQ-015 instr_o  out  32  head instruction.
REQ-016 instr_pc_o  out  XLEN  PC of head instruction.
REQ-017 instr_ready_i  in  1  decode accepts head when instr_valid_o & instr_ready_i.

Function
REQ-018 Buffer SHALL be a DEPTH-entry circular queue: allocate pointer, fill pointer, head pointer, each log2(DEPTH) bits, wrapping modulo DEPTH; each entry stores PC (XLEN), instruction (32), filled flag.
REQ-019 On grant, entry at allocate pointer SHALL take current fetch PC, filled=0; allocate pointer +1; fetch PC += 4 (modulo 2^XLEN).
REQ-020 On imem_rvalid_i with discard count 0, entry at fill pointer SHALL take imem_rdata_i, filled=1; fill pointer +1.
REQ-021 On imem_rvalid_i with discard count > 0, response SHALL be dropped and discard count decremented by 1.
REQ-022 imem_req_o SHALL = run & ~redirect_i & (allocated entries + discard count < DEPTH); run is a flop cleared by reset, set on first edge after reset release.
REQ-023 instr_valid_o SHALL = head entry allocated & filled; instr_o/instr_pc_o driven from head entry; on accept, head pointer +1 and entry freed.
REQ-024 Grant, fill and pop SHALL all be allowed in the same cycle; a response may fill and, from the next cycle, be presented (fill-to-output latency 1 cycle).
REQ-025 On redirect_i: all entries freed, all pointers equal, fetch PC <= {redirect_pc_i[XLEN-1:2],2'b00}; discard count <= discard count + allocated-unfilled entries - (imem_rvalid_i ? 1 : 0); no grant taken that cycle; pop ignored.
REQ-026 Redirect SHALL take priority over grant, fill and pop in the same cycle; first request at new PC is presented the following cycle.
REQ-027 Full condition (allocated + discard = DEPTH) SHALL hold imem_req_o low; it deasserts only via pop or dropped response.
REQ-028 imem_rvalid_i with no unfilled entry and discard count 0 is a protocol violation: ignored, flagged by simulation assertion.
REQ-029 Discard count SHALL be log2(DEPTH)+1 bits and never exceed DEPTH.

Reset
REQ-030 While reset_sync high: fetch PC = RESET_PC, pointers 0, all filled flags 0, discard count 0, run 0; imem_req_o, instr_valid_o = 0; imem_addr_o = RESET_PC[ADDR_W-1:0]; instr_o, instr_pc_o = 0.
REQ-031 Reset asserted mid-operation SHALL discard all entries and outstanding responses immediately; responses arriving after release for pre-reset grants are the environment's responsibility.

Verification
REQ-032 Reset release, gnt=1, rvalid 1 cycle after each grant, ready=1 -> addresses 0x0,0x4,0x8... in consecutive cycles; instr_pc_o sequence 0x0,0x4,0x8 with matching data.
REQ-033 DEPTH=4, ready=0, immediate responses -> exactly 4 grants, then imem_req_o=0; one pop -> one further grant at PC 0x10.
REQ-034 Two grants outstanding (no rvalid), redirect to 0x1002 -> next request address 0x1000, two subsequent rvalids dropped, first instr_pc_o = 0x1000.
REQ-035 Redirect in same cycle as rvalid with one other grant outstanding -> discard count 1; next rvalid dropped; following response fills PC 0x1000 entry.
REQ-036 Fetch PC 0xFFFF_FFFF_FFFF_FFFC granted -> next PC wraps to 0x0; pointers wrap after DEPTH allocations without loss.
REQ-037 reset_sync pulsed asynchronously with full buffer -> outputs zero before next clock edge; after release fetch restarts at RESET_PC.
